// File: rtl/matrix_scan_encoder.sv
// matrix_scan_encoder: scans a COLS x ROWS key matrix one column at a time,
// samples the rows at the end of each column dwell, debounces whole-frame
// results and reports committed keys as a binary code with a valid strobe.
// Optional feature: define AUTO_REPEAT_EN to re-strobe key_valid every
// REPEAT_FRAMES frames while a single key stays committed.
module matrix_scan_encoder #(
   parameter int COLS           = 5,
   parameter int ROWS           = 7,
   parameter int CODE_W         = 6,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_FRAMES  = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [COLS-1:0]   col_out,
   input  logic [ROWS-1:0]   row_in,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   output logic              key_held,
   output logic              multi_key
);

   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

   // Elaboration-time sanity checks on the configuration
   if ((2 ** CODE_W) < (COLS * ROWS)) begin : g_bad_code_w
      $error("CODE_W too small for COLS*ROWS key codes");
   end
   if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
      $error("DEBOUNCE_SCANS must be at least 1");
   end
   if (REPEAT_FRAMES < 1) begin : g_bad_repeat
      $error("REPEAT_FRAMES must be at least 1");
   end

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;
   typedef enum logic [1:0] {RES_NONE = 2'd0, RES_SINGLE = 2'd1, RES_MULTI = 2'd2} res_t;

   state_t            state;
   state_t            state_next;
   logic [DIV_W-1:0]  dwell_cnt;
   logic [COL_W-1:0]  col_idx;
   logic [1:0]        acc_hits;
   logic [CODE_W-1:0] acc_code;
   logic [STB_W-1:0]  stable_cnt;
   res_t              prev_kind;
   logic [CODE_W-1:0] prev_code;
   res_t              com_kind;
   logic [CODE_W-1:0] com_code;

   logic              scanning;
   logic              sample;
   logic              frame_end;
   logic [1:0]        hits_new;
   logic [CODE_W-1:0] code_new;
   res_t              frame_kind;
   logic [CODE_W-1:0] frame_code;
   logic [STB_W-1:0]  stable_new;
   logic              commit;

   // Hit count plus the rows seen in this sample, saturating at two
   function automatic logic [1:0] sat_hits(input logic [1:0] hits, input logic [ROWS-1:0] rows);
      int total = int'(hits);
      for (int r = 0; r < ROWS; r++) total += int'(rows[r]);
      return (total >= 2) ? 2'd2 : total[1:0];
   endfunction

   // Key code of the lowest asserted row in the given column
   function automatic logic [CODE_W-1:0] hit_code(input logic [COL_W-1:0] col, input logic [ROWS-1:0] rows);
      int row = 0;
      for (int r = ROWS - 1; r >= 0; r--) if (rows[r]) row = r;
      return CODE_W'(int'(col) * ROWS + row);
   endfunction

   // State register: IDLE while disabled, SCAN while enabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: scanning simply follows the enable
   always_comb begin
      state_next = en ? SCAN : IDLE;
   end

   // Column drive: one-hot for the current column while scanning
   always_comb begin
      col_out = '0;
      if (state == SCAN) col_out[col_idx] = 1'b1;
   end

   // Frame evaluation for the current sample, including debounce decision
   always_comb begin
      scanning   = (state == SCAN) && en;
      sample     = scanning && (dwell_cnt == DIV_W'(SCAN_DIV - 1));
      frame_end  = sample && (col_idx == COL_W'(COLS - 1));
      hits_new   = sat_hits(acc_hits, row_in);
      code_new   = ((acc_hits == 2'd0) && (row_in != '0)) ? hit_code(col_idx, row_in) : acc_code;
      frame_kind = RES_MULTI;
      if (hits_new == 2'd0)      frame_kind = RES_NONE;
      else if (hits_new == 2'd1) frame_kind = RES_SINGLE;
      frame_code = (frame_kind == RES_SINGLE) ? code_new : '0;
      if ((frame_kind == prev_kind) && (frame_code == prev_code))
         stable_new = (stable_cnt == STB_W'(DEBOUNCE_SCANS)) ? stable_cnt : stable_cnt + STB_W'(1);
      else
         stable_new = STB_W'(1);
      commit = frame_end && (stable_new == STB_W'(DEBOUNCE_SCANS)) &&
               ((frame_kind != com_kind) || (frame_code != com_code));
   end

   // Scan sequencing, frame accumulation and debounce history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_cnt  <= '0;
         col_idx    <= '0;
         acc_hits   <= '0;
         acc_code   <= '0;
         stable_cnt <= '0;
         prev_kind  <= RES_NONE;
         prev_code  <= '0;
      end else if (!scanning) begin
         dwell_cnt  <= '0;
         col_idx    <= '0;
         acc_hits   <= '0;
         acc_code   <= '0;
         stable_cnt <= '0;
         prev_kind  <= RES_NONE;
         prev_code  <= '0;
      end else if (sample) begin
         dwell_cnt <= '0;
         if (frame_end) begin
            col_idx    <= '0;
            acc_hits   <= '0;
            acc_code   <= '0;
            stable_cnt <= stable_new;
            prev_kind  <= frame_kind;
            prev_code  <= frame_code;
         end else begin
            col_idx  <= col_idx + COL_W'(1);
            acc_hits <= hits_new;
            acc_code <= code_new;
         end
      end else begin
         dwell_cnt <= dwell_cnt + DIV_W'(1);
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
   logic [REP_W-1:0] rep_cnt;
`endif

   // Committed result and key outputs, updated at the edge after a frame end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         com_kind  <= RES_NONE;
         com_code  <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         key_valid <= 1'b0;
         if (commit) begin
            com_kind <= frame_kind;
            com_code <= frame_code;
`ifdef AUTO_REPEAT_EN
            rep_cnt  <= '0;
`endif
            case (frame_kind)
               RES_SINGLE: begin
                  key_code  <= frame_code;
                  key_held  <= 1'b1;
                  multi_key <= 1'b0;
                  key_valid <= 1'b1;
               end
               RES_MULTI: begin
                  key_held  <= 1'b0;
                  multi_key <= 1'b1;
               end
               default: begin
                  key_held  <= 1'b0;
                  multi_key <= 1'b0;
               end
            endcase
         end
`ifdef AUTO_REPEAT_EN
         else if (frame_end && key_held) begin
            if (rep_cnt == REP_W'(REPEAT_FRAMES - 1)) begin
               key_valid <= 1'b1;
               rep_cnt   <= '0;
            end else begin
               rep_cnt <= rep_cnt + REP_W'(1);
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_matrix_scan_encoder.sv
// Testbench for matrix_scan_encoder: directed scenarios followed by random
// key frames, checked against a frame-level behavioural model.
module tb_matrix_scan_encoder;

   localparam int COLS = 5;
   localparam int ROWS = 7;
   localparam int CODE_W = 6;
   localparam int SCAN_DIV = 4;
   localparam int DB = 2;
   localparam int REP = 3;
   localparam int FRAME = COLS * SCAN_DIV;
   localparam int NKEYS = COLS * ROWS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              en = 1'b0;
   logic [COLS-1:0]   col_out;
   logic [ROWS-1:0]   row_in = '0;
   logic [CODE_W-1:0] key_code;
   logic              key_valid;
   logic              key_held;
   logic              multi_key;

   matrix_scan_encoder #(
      .COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W), .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE_SCANS(DB), .REPEAT_FRAMES(REP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .col_out(col_out), .row_in(row_in),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .multi_key(multi_key)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state: frame results since last clear, committed result
   int          hist[$];
   int          m_com = -1;       // -1 none, -2 multi, >=0 single code
   logic [5:0]  m_code = '0;
   logic        m_held = 1'b0;
   logic        m_multi = 1'b0;
   logic        m_pend = 1'b0;
   int          m_rep = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_res(input logic [NKEYS-1:0] k);
      int n = $countones(k);
      if (n == 0) return -1;
      if (n > 1) return -2;
      for (int i = 0; i < NKEYS; i++) if (k[i]) return i;
      return -1;
   endfunction

   task automatic model_frame(input int r);
      hist.push_back(r);
      if (hist.size() > DB) void'(hist.pop_front());
      if (hist.size() == DB && hist[0] == hist[DB-1] && r != m_com) begin
         m_com = r;
         m_rep = 0;
         if (r >= 0) begin
            m_code = 6'(r); m_held = 1'b1; m_multi = 1'b0; m_pend = 1'b1;
         end else if (r == -2) begin
            m_held = 1'b0; m_multi = 1'b1;
         end else begin
            m_held = 1'b0; m_multi = 1'b0;
         end
      end
`ifdef AUTO_REPEAT_EN
      else if (m_held) begin
         m_rep++;
         if (m_rep == REP) begin m_pend = 1'b1; m_rep = 0; end
      end
`endif
   endtask

   task automatic model_reset();
      hist.delete();
      m_com = -1; m_code = '0; m_held = 1'b0; m_multi = 1'b0; m_pend = 1'b0; m_rep = 0;
   endtask

   task automatic check_outputs();
      check_val("key_code", 64'(key_code), 64'(m_code));
      check_val("key_held", 64'(key_held), 64'(m_held));
      check_val("multi_key", 64'(multi_key), 64'(m_multi));
   endtask

   // Called just after a posedge with en=1 and the DUT at frame cycle 0
   task automatic run_frame(input logic [NKEYS-1:0] keys, input int abort_at);
      logic [COLS-1:0] exp_col;
      for (int i = 0; i < FRAME; i++) begin
         #1;
         if (i == abort_at) begin
            en = 1'b0;
            row_in = '0;
            exp_col = COLS'(1) << (i / SCAN_DIV);
            @(negedge clk);
            check_val("col_out_abort", 64'(col_out), 64'(exp_col));
            check_val("key_valid", 64'(key_valid), 64'(0));
            @(posedge clk);
            #1 en = 1'b1;
            @(negedge clk);
            check_val("col_out_off", 64'(col_out), 64'(0));
            check_val("key_valid_off", 64'(key_valid), 64'(0));
            check_outputs();
            @(posedge clk);
            hist.delete();
            return;
         end
         if ((i % SCAN_DIV) != SCAN_DIV - 1 && $urandom_range(0, 1) == 1)
            row_in = ROWS'($urandom);
         else
            row_in = keys[(i / SCAN_DIV) * ROWS +: ROWS];
         exp_col = COLS'(1) << (i / SCAN_DIV);
         @(negedge clk);
         check_val("col_out", 64'(col_out), 64'(exp_col));
         if (i == 0) begin
            check_val("key_valid", 64'(key_valid), 64'(m_pend));
            m_pend = 1'b0;
            check_outputs();
         end else begin
            check_val("key_valid", 64'(key_valid), 64'(0));
         end
         @(posedge clk);
      end
      model_frame(frame_res(keys));
   endtask

   task automatic start_scan();
      #1 en = 1'b1;
      @(posedge clk);
   endtask

   function automatic logic [NKEYS-1:0] one_key(input int idx);
      logic [NKEYS-1:0] k = '0;
      k[idx] = 1'b1;
      return k;
   endfunction

   logic [NKEYS-1:0] k17;
   logic [NKEYS-1:0] kmulti;
   logic [NKEYS-1:0] knone;
   logic [NKEYS-1:0] kcur;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      k17 = one_key(2 * ROWS + 3);
      kmulti = one_key(1 * ROWS + 0) | one_key(4 * ROWS + 6);
      knone = '0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_col_out", 64'(col_out), 64'(0));
      check_val("rst_key_valid", 64'(key_valid), 64'(0));
      check_outputs();
      rst = 1'b0;
      @(posedge clk);
      start_scan();

      // Single key 17 commits after frame 2, then release
      run_frame(k17, FRAME);
      run_frame(k17, FRAME);
      run_frame(k17, FRAME);
      run_frame(knone, FRAME);
      run_frame(knone, FRAME);
      run_frame(knone, FRAME);
      // Two keys together: multi, no strobe
      run_frame(kmulti, FRAME);
      run_frame(kmulti, FRAME);
      run_frame(kmulti, FRAME);
      run_frame(knone, FRAME);
      run_frame(knone, FRAME);
      // Toggling key never stabilises
      for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? k17 : knone, FRAME);
      // Enable dropped mid-press, then re-enabled
      run_frame(k17, FRAME);
      run_frame(k17, 10);
      run_frame(k17, FRAME);
      run_frame(k17, FRAME);
      run_frame(k17, FRAME);

      // Asynchronous reset in the middle of a dwell
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_val("arst_col_out", 64'(col_out), 64'(0));
      check_val("arst_key_valid", 64'(key_valid), 64'(0));
      model_reset();
      check_outputs();
      en = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk);
      start_scan();

      // Random frames
      kcur = '0;
      for (int f = 0; f < 80; f++) begin
         int r = $urandom_range(0, 99);
         if (r < 40) kcur = kcur;
         else if (r < 60) kcur = '0;
         else if (r < 88) kcur = one_key($urandom_range(0, NKEYS - 1));
         else kcur = one_key($urandom_range(0, NKEYS - 1)) | one_key($urandom_range(0, NKEYS - 1));
         run_frame(kcur, ($urandom_range(0, 99) < 8) ? $urandom_range(1, FRAME - 1) : FRAME);
      end

      // Final pending strobe and outputs
      #1 row_in = '0;
      @(negedge clk);
      check_val("key_valid_tail", 64'(key_valid), 64'(m_pend));
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/matrix_scan_encoder.md
Name: matrix_scan_encoder

Overview:
- Scanning encoder for the 5-column switch/LED matrix. It is the input-side counterpart of the column decode logic.
- Drives one column at a time, samples the row lines and debounces over whole scan frames.
- Emits a binary key code with a one-cycle valid strobe.
- Sits between the physical matrix pins and the control logic that consumes key events.

Parameters:
- COLS, 5: number of driven column lines.
- ROWS, 7: number of sensed row lines.
- CODE_W, 6: key_code width; must satisfy 2^CODE_W >= COLS*ROWS.
- SCAN_DIV, 1000: clock cycles each column stays driven (dwell).
- DEBOUNCE_SCANS, 4: consecutive identical frame results required to commit a change; must be >= 1.
- REPEAT_FRAMES, 50: frames between auto-repeat strobes; used only with AUTO_REPEAT_EN.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: scan enable.
- col_out, output, COLS: one-hot active-high column drive.
- row_in, input, ROWS: active-high row sense. Already synchronised upstream.
- key_code, output, CODE_W: committed key = col*ROWS + row.
- key_valid, output, 1: one-cycle strobe when a new single key is committed.
- key_held, output, 1: level; a single committed key is currently pressed.
- multi_key, output, 1: level; committed result is two or more keys.

Behaviour:
- Reset (async, rst=1): all of the following take these values immediately.
  - col_out=0, key_code=0, key_valid=0, key_held=0, multi_key=0.
  - Column index, dwell counter, frame accumulators, stable counter: 0.
  - Previous frame result and committed result: NONE.
- States:
  - IDLE: en=0; col_out=0.
  - SCAN: en=1.
  - IDLE->SCAN on en=1. The first cycle of SCAN drives column 0.
- Dwell: col_out=(1<<col_idx) for exactly SCAN_DIV cycles.
  - row_in is sampled only on the last dwell cycle (settling time).
  - col_idx then advances; it wraps COLS-1 -> 0.
- Frame accumulation, per sample:
  - Add popcount(row_in) to the frame hit count, saturating at 2.
  - Record the first hit code: lowest column first, then lowest row.
- Frame end is the sample of column COLS-1. The frame result is:
  - NONE if hits=0.
  - SINGLE(code) if hits=1.
  - MULTI if hits>=2.
  - Accumulators clear for the next frame; there is no dead cycle between frames.
- Debounce:
  - If the frame result equals the previous frame result (including the code), stable_cnt increments, saturating at DEBOUNCE_SCANS.
  - Otherwise stable_cnt=1.
  - The previous frame result is then updated.
- Commit: when stable_cnt==DEBOUNCE_SCANS and the result differs from the committed result. Outputs register one cycle after the frame-end sample.
  - SINGLE: key_code=code, key_held=1, multi_key=0, key_valid=1 for one cycle.
  - NONE: key_held=0, multi_key=0. No strobe. key_code holds its last value.
  - MULTI: multi_key=1, key_held=0. No strobe. key_code unchanged.
- Direct SINGLE(a) -> SINGLE(b) with no NONE in between commits b with a fresh strobe.
- Latency: a key stable from the start of a frame commits 1 cycle after the end of frame number DEBOUNCE_SCANS.
- en deasserted mid-frame:
  - Abort the frame; col_out=0 next cycle.
  - Clear the dwell counter, col_idx, accumulators, stable_cnt, and the previous frame result (to NONE).
  - Committed outputs are retained.
  - Re-enable starts a fresh frame at column 0.
- A partial press inside a frame is an ordinary unstable frame; it is absorbed by the debounce.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - While key_held=1, a frame counter runs; it resets on every commit.
  - Every REPEAT_FRAMES completed frames with the same committed SINGLE, key_valid pulses one cycle at frame end +1.
  - key_code is unchanged by repeat strobes.
  - Release or MULTI stops repeat immediately.
- Undefined:
  - No repeat counter is synthesised.
  - key_valid fires only on commit.

Test Plan (COLS=5, ROWS=7, SCAN_DIV=4, DEBOUNCE_SCANS=2, frame=20 cycles):
- Reset then en=1 -> col_out sequence 00001,00010,00100,01000,10000, each held 4 cycles, repeating. Async rst pulse mid-dwell -> col_out=0 and all outputs 0 without a clock edge.
- Row 3 asserted whenever column 2 is driven, from frame start -> after frame 2, key_code=17, key_valid=1 for exactly 1 cycle (cycle 40 after scan start), key_held=1. Release for 2 frames -> key_held=0, no strobe.
- Keys (col1,row0) and (col4,row6) held together for 2 frames -> multi_key=1, key_valid never asserted, key_code unchanged.
- Key toggled every other frame -> stable_cnt never reaches 2; no commit and no strobe.
- en dropped in the middle of frame 2 of a valid press -> col_out=0 next cycle, no commit. Re-enable -> commit after 2 further full frames.
- With AUTO_REPEAT_EN and REPEAT_FRAMES=3, key 17 held for 10 frames -> strobes after frames 2, 5 and 8. Without the macro -> a single strobe only.
